dco_cap_coder_slew: RTL and testbench
=====================================

Name: dco_cap_coder_slew

Overview:
- Parametrised successor to the DCO capacitor-bank row/column coder.
- Converts a binary tuning word into zero-active row-all enables, a one-hot active row, and a serpentine thermometer column select for a (2^ROW_W) x (2^COL_W) unit-cap array.
- Adds non-square arrays, a programmable reset code, and a per-update slew limiter so that large tuning-word jumps reach the array as bounded steps.
- A settled flag reports when the applied code equals the requested word. Sits between the loop filter/ADPLL control and the DCO cap bank.

Parameters:
- ROW_W, 4, log2 of row count; R = 2^ROW_W.
- COL_W, 4, log2 of column count; C = 2^COL_W.
- WORD_W, ROW_W+COL_W, tuning word width; fixed relation, not independently overridable.
- RST_WORD, 2^(WORD_W-1), applied code after reset (mid-scale).
- MAX_STEP, 8, max code change per enabled update; legal range 1..2^WORD_W-1.

Ports:
- clk  in  1  DCO control clock; all registers update on the falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  update enable; when low, all registers hold.
- direct  in  1  1 = bypass slew limiter (cur jumps to word); 0 = slew-limited.
- word  in  WORD_W  requested tuning code (target), sampled on each enabled falling edge.
- cur_word  out  WORD_W  code currently applied to the array (registered).
- settled  out  1  registered; 1 when cur_word == word as sampled at the last enabled edge.
- r_all  out  R  zero-active full-row enables.
- row  out  R  one-hot partial-row select.
- col  out  C  column thermometer for the partial row.

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-slew):
  - cur_word = RST_WORD; settled = 0.
  - r_all, row and col = decode(RST_WORD).
  - For defaults this is r_all=16'hFF00, row=16'h0100, col=16'h0000.
- Enabled falling edge (en=1):
  - d = word - cur_word, computed signed in WORD_W+1 bits.
  - If direct=1 or |d| <= MAX_STEP: cur_next = word.
  - Else: cur_next = cur_word + MAX_STEP when d>0, or cur_word - MAX_STEP when d<0.
  - No wrap-around is possible: the step never overshoots word, and word is always in range.
  - Registered on the same edge: cur_word <= cur_next; settled <= (cur_next == word); outputs <= decode(cur_next).
  - Outputs are therefore always consistent with cur_word, with zero extra latency.
- en=0 edge: everything holds, settled included, even if word changes.
- word changing mid-slew: each edge re-targets to the new word; no restart state.
- Slew latency: ceil(|word - cur_word| / MAX_STEP) enabled edges; direct mode takes 1 edge.
- decode(v), with r = v >> COL_W and c = v mod C:
  - r_all[i] = 0 for i < r, else 1.
  - row[i] = 1 only for i == r.
  - r even: col[j] = 1 for j < c (filled from LSB).
  - r odd: col[j] = 1 for j >= C-c (filled from MSB).
  - c = 0 gives col all zero.
- There is no separate FSM: the block's states are SLEWING (settled=0, cur_word != word) and SETTLED (settled=1). Transitions are evaluated only on enabled edges; reset forces SLEWING semantics (settled=0).
- Outputs must be glitch-free registers. No combinational path from word to any output.

Test Plan:
- Reset: drive rst_n low, hold word=0 -> cur_word=128, r_all=16'hFF00, row=16'h0100, col=16'h0000, settled=0. Release rst_n -> these values hold until the first enabled edge.
- Slew up: direct=0, en=1, word=200 from 128 -> cur_word steps 136,144,...,200 over 9 falling edges; settled rises on the 9th edge. Final outputs: r_all=16'hF000, row=16'h1000, col=16'h00FF.
- Odd-row serpentine and small step: word=53 in direct mode, then word=51 with direct=0.
  - After word=53: r_all=16'hFFF8, row=16'h0008, col=16'hF800.
  - After word=51 (|d|=2 < 8): one edge -> cur_word=51, col=16'hE000, settled=1.
- Direct full-scale: direct=1, word=255 from 128 -> one edge gives cur_word=255, r_all=16'h8000, row=16'h8000, col=16'hFFFE, settled=1.
- Enable gating and re-target:
  - Mid-slew at cur_word=144, set en=0 and change word=100 -> outputs frozen for 5 edges.
  - Set en=1 -> steps 136,128,...,104,100, with settled=1 at cur_word=100.
- Reset mid-slew: pulse rst_n low between edges while cur_word=176 -> outputs return to decode(128) immediately, asynchronously, and settled drops to 0.

Source files
------------

// File: rtl/dco_cap_coder_slew_if.sv
// Purpose : control/status bundle between the ADPLL loop control and the DCO cap coder.
// Latency : n/a (wiring only).
// Backpressure: none; the coder samples word/direct on every enabled falling edge.
//
// Signals:
//   en       update enable (controller -> coder)
//   direct   1 = bypass slew limiter (controller -> coder)
//   word     requested tuning code (controller -> coder)
//   cur_word code currently applied to the array (coder -> controller/bank)
//   settled  cur_word matches the word sampled at the last enabled edge
//   r_all    zero-active full-row enables, R bits
//   row      one-hot partial-row select, R bits
//   col      serpentine column thermometer for the partial row, C bits
interface dco_cap_coder_slew_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
);
    localparam int WORD_W = ROW_W + COL_W;
    localparam int R      = 2 ** ROW_W;
    localparam int C      = 2 ** COL_W;

    logic              en;
    logic              direct;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] cur_word;
    logic              settled;
    logic [R-1:0]      r_all;
    logic [R-1:0]      row;
    logic [C-1:0]      col;

    // Loop control side.
    modport master (
        output en,
        output direct,
        output word,
        input  cur_word,
        input  settled,
        input  r_all,
        input  row,
        input  col
    );

    // Coder side.
    modport slave (
        input  en,
        input  direct,
        input  word,
        output cur_word,
        output settled,
        output r_all,
        output row,
        output col
    );
endinterface

// File: rtl/dco_cap_coder_slew.sv
// Purpose : binary tuning word -> row-all / one-hot row / serpentine column code for a
//           (2^ROW_W) x (2^COL_W) unit-cap array, with per-update slew limiting.
// Latency : one enabled falling edge per step; ceil(|word-cur_word|/MAX_STEP) edges to settle
//           (one edge in direct mode). Backpressure: none; en=0 freezes all state.
//
// Ports:
//   clk      DCO control clock, all state updates on the falling edge
//   rst_n    asynchronous active-low reset, returns the array to RST_WORD
//   bus      dco_cap_coder_slew_if.slave (en, direct, word in; cur_word, settled,
//            r_all, row, col out -- all outputs are registers)
module dco_cap_coder_slew #(
    parameter int ROW_W    = 4,
    parameter int COL_W    = 4,
    parameter int RST_WORD = 2 ** (ROW_W + COL_W - 1),
    parameter int MAX_STEP = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dco_cap_coder_slew_if.slave  bus
);
    localparam int WORD_W = ROW_W + COL_W;
    localparam int R      = 2 ** ROW_W;
    localparam int C      = 2 ** COL_W;

    localparam logic [WORD_W-1:0]        RST_CODE = WORD_W'(RST_WORD);
    localparam logic [WORD_W-1:0]        STEP_U   = WORD_W'(MAX_STEP);
    localparam logic signed [WORD_W:0]   STEP_S   = (WORD_W + 1)'(MAX_STEP);

    typedef struct packed {
        logic [R-1:0] r_all;
        logic [R-1:0] row;
        logic [C-1:0] col;
    } dec_t;

    // Array decode. Rows below the active row are fully on (zero-active r_all),
    // the active row is partially filled; odd rows fill from the MSB so the
    // switched capacitance walks the array in a serpentine and each code step
    // toggles exactly one unit cell.
    function automatic dec_t decode(input logic [WORD_W-1:0] v);
        dec_t             o;
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
        r = v[WORD_W-1:COL_W];
        c = v[COL_W-1:0];
        o = '0;
        for (int i = 0; i < R; i++) begin
            o.r_all[i] = (i >= int'(r));
            o.row[i]   = (i == int'(r));
        end
        for (int j = 0; j < C; j++) begin
            if (r[0]) begin
                o.col[j] = (j >= C - int'(c));
            end else begin
                o.col[j] = (j < int'(c));
            end
        end
        return o;
    endfunction

    logic [WORD_W-1:0]        cur_q;
    logic                     settled_q;
    dec_t                     dec_q;

    logic signed [WORD_W:0]   diff;
    logic signed [WORD_W:0]   mag;
    logic [WORD_W-1:0]        cur_nxt;

    // Distance to target, one extra bit so the sign is never lost.
    assign diff = $signed({1'b0, bus.word}) - $signed({1'b0, cur_q});
    assign mag  = diff[WORD_W] ? -diff : diff;

    // The step is only taken when |diff| > MAX_STEP, so it can never
    // overshoot the target or wrap past either end of the code range.
    always_comb begin
        cur_nxt = bus.word;
        if (!bus.direct && (mag > STEP_S)) begin
            if (diff[WORD_W]) begin
                cur_nxt = cur_q - STEP_U;
            end else begin
                cur_nxt = cur_q + STEP_U;
            end
        end
    end

    // Decode of cur_nxt is registered alongside cur_word so the array code
    // never lags the applied word and no path from word reaches an output.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q     <= RST_CODE;
            settled_q <= 1'b0;
            dec_q     <= decode(RST_CODE);
        end else if (bus.en) begin
            cur_q     <= cur_nxt;
            settled_q <= (cur_nxt == bus.word);
            dec_q     <= decode(cur_nxt);
        end
    end

    assign bus.cur_word = cur_q;
    assign bus.settled  = settled_q;
    assign bus.r_all    = dec_q.r_all;
    assign bus.row      = dec_q.row;
    assign bus.col      = dec_q.col;

endmodule

// File: tb/tb_dco_cap_coder_slew.sv
// Purpose : directed check of dco_cap_coder_slew against a behavioural slew/decode model.
// Latency : model and DUT both update on enabled falling edges; outputs compared on rising edges.
// Backpressure: none.
module tb_dco_cap_coder_slew;
    logic clk;
    logic rst_n;

    int checks;
    int errors;
    bit chk_en;

    dco_cap_coder_slew_if #(.ROW_W(4), .COL_W(4)) bus ();

    dco_cap_coder_slew #(
        .ROW_W(4),
        .COL_W(4),
        .RST_WORD(128),
        .MAX_STEP(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_cur;
    bit m_set;

    always @(negedge clk or negedge rst_n) begin
        int d;
        if (!rst_n) begin
            m_cur = 128;
            m_set = 1'b0;
        end else if (bus.en === 1'b1) begin
            d = int'(bus.word) - m_cur;
            if (bus.direct || (d <= 8 && d >= -8)) m_cur = int'(bus.word);
            else if (d > 0)                        m_cur = m_cur + 8;
            else                                   m_cur = m_cur - 8;
            m_set = (m_cur == int'(bus.word));
        end
    end

    function automatic logic [15:0] m_rall(input int v);
        logic [15:0] ones;
        ones = 16'hFFFF;
        return ones << (v / 16);
    endfunction

    function automatic logic [15:0] m_row(input int v);
        logic [15:0] one;
        one = 16'h0001;
        return one << (v / 16);
    endfunction

    function automatic logic [15:0] m_col(input int v);
        int r;
        int c;
        int mask;
        r    = v / 16;
        c    = v % 16;
        mask = (1 << c) - 1;
        if (r % 2 == 1) mask = mask << (16 - c);
        return mask[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active (falling) edge.
    always @(posedge clk) begin
        if (chk_en) begin
            check("model cur_word", 32'(bus.cur_word), 32'(m_cur));
            check("model settled",  32'(bus.settled),  32'(m_set));
            check("model r_all",    32'(bus.r_all),    32'(m_rall(m_cur)));
            check("model row",      32'(bus.row),      32'(m_row(m_cur)));
            check("model col",      32'(bus.col),      32'(m_col(m_cur)));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic expect_all(input string tag, input int cw, input bit st,
                              input logic [15:0] ra, input logic [15:0] rw, input logic [15:0] cl);
        check({tag, " cur_word"}, 32'(bus.cur_word), 32'(cw));
        check({tag, " settled"},  32'(bus.settled),  32'(st));
        check({tag, " r_all"},    32'(bus.r_all),    32'(ra));
        check({tag, " row"},      32'(bus.row),      32'(rw));
        check({tag, " col"},      32'(bus.col),      32'(cl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        rst_n      = 1'b1;
        bus.en     = 1'b0;
        bus.direct = 1'b0;
        bus.word   = '0;

        // Reset, including hold after release with en=0.
        #2 rst_n = 1'b0;
        #1 expect_all("reset", 128, 1'b0, 16'hFF00, 16'h0100, 16'h0000);
        edges(2);
        rst_n = 1'b1;
        chk_en = 1'b1;
        edges(2);
        expect_all("post-reset hold", 128, 1'b0, 16'hFF00, 16'h0100, 16'h0000);

        // Slew up 128 -> 200 in steps of 8.
        bus.en = 1'b1; bus.direct = 1'b0; bus.word = 8'd200;
        edges(1);
        expect_all("slew step1", 136, 1'b0, 16'hFF00, 16'h0100, 16'h00FF);
        edges(7);
        check("slew step8 cur_word", 32'(bus.cur_word), 32'd192);
        check("slew step8 settled",  32'(bus.settled),  32'd0);
        edges(1);
        expect_all("slew done", 200, 1'b1, 16'hF000, 16'h1000, 16'h00FF);

        // Odd-row serpentine, then a small non-direct step.
        bus.direct = 1'b1; bus.word = 8'd53;
        edges(1);
        expect_all("direct 53", 53, 1'b1, 16'hFFF8, 16'h0008, 16'hF800);
        bus.direct = 1'b0; bus.word = 8'd51;
        edges(1);
        expect_all("small step 51", 51, 1'b1, 16'hFFF8, 16'h0008, 16'hE000);

        // Direct full-scale from mid-scale.
        bus.direct = 1'b1; bus.word = 8'd128;
        edges(1);
        bus.word = 8'd255;
        edges(1);
        expect_all("direct 255", 255, 1'b1, 16'h8000, 16'h8000, 16'hFFFE);

        // Enable gating with re-target.
        bus.word = 8'd128;
        edges(1);
        bus.direct = 1'b0; bus.word = 8'd200;
        edges(2);
        check("gate start cur_word", 32'(bus.cur_word), 32'd144);
        bus.en = 1'b0; bus.word = 8'd100;
        edges(5);
        expect_all("gated", 144, 1'b0, 16'hFE00, 16'h0200, 16'h0000);
        bus.en = 1'b1;
        edges(1);
        check("retarget step1 cur_word", 32'(bus.cur_word), 32'd136);
        edges(4);
        check("retarget step5 cur_word", 32'(bus.cur_word), 32'd104);
        check("retarget step5 settled",  32'(bus.settled),  32'd0);
        edges(1);
        expect_all("retarget done", 100, 1'b1, 16'hFFC0, 16'h0040, 16'h000F);

        // Asynchronous reset in the middle of a slew.
        bus.direct = 1'b1; bus.word = 8'd128;
        edges(1);
        bus.direct = 1'b0; bus.word = 8'd255;
        edges(6);
        expect_all("pre-reset slew", 176, 1'b0, 16'hF800, 16'h0800, 16'h0000);
        rst_n = 1'b0;
        #1 expect_all("async reset", 128, 1'b0, 16'hFF00, 16'h0100, 16'h0000);
        #1 rst_n = 1'b1;
        edges(1);
        expect_all("resume after reset", 136, 1'b0, 16'hFF00, 16'h0100, 16'h00FF);

        // Slew down to zero exercises the low end of the range.
        bus.word = 8'd0;
        edges(17);
        expect_all("slew to zero", 0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
